// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data-memory port arbiter between the DM stage and an external requester
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_lock,
    input  logic [63:0] ext_addr,
    input  logic [63:0] ext_wdata,
    input  logic [3:0]  ext_xfer_size,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [63:0] ext_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_xfer_size,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [63:0] mem_rdata
);

    typedef enum logic {
        CPU_OWN    = 1'b0,
        EXT_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] LOCK_MAX   = 4'(MAX_LOCK);

    state_t     state, state_next;
    logic [3:0] starve_cnt, starve_next, starve_eff;
    logic [3:0] lock_cnt, lock_next;
    logic       ext_grant, cpu_grant, lock_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CPU_OWN;
            starve_cnt <= 4'd0;
            lock_cnt   <= 4'd0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= 64'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            lock_cnt   <= lock_next;
            ext_rvalid <= ext_grant && !ext_we;
            if (ext_grant && !ext_we)
                ext_rdata <= mem_rdata;
        end
    end

    // A lock that cannot continue falls back to CPU_OWN arbitration in the same cycle.
    always_comb begin
        lock_hold  = (state == EXT_LOCKED) && ext_req && ext_lock && (lock_cnt < LOCK_MAX);
        starve_eff = (state == EXT_LOCKED) ? 4'd0 : starve_cnt;
        ext_grant  = 1'b0;
        cpu_grant  = 1'b0;
        state_next = CPU_OWN;
        lock_next  = 4'd0;
        if (!reset) begin
            if (lock_hold) begin
                ext_grant  = 1'b1;
                state_next = EXT_LOCKED;
                lock_next  = lock_cnt + 4'd1;
            end else begin
                ext_grant = ext_req && (!cpu_req || starve_eff == STARVE_MAX);
                cpu_grant = cpu_req && !ext_grant;
                if (ext_grant && ext_lock) begin
                    state_next = EXT_LOCKED;
                    lock_next  = 4'd1;
                end
            end
        end
        if (ext_req && !ext_grant)
            starve_next = (starve_eff >= STARVE_MAX) ? STARVE_MAX : starve_eff + 4'd1;
        else
            starve_next = 4'd0;
    end

    always_comb begin
        mem_addr      = 64'd0;
        mem_wdata     = 64'd0;
        mem_xfer_size = 4'd0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        if (ext_grant) begin
            mem_addr      = ext_addr;
            mem_wdata     = ext_wdata;
            mem_xfer_size = ext_xfer_size;
            mem_we        = ext_we;
            mem_re        = !ext_we;
        end else if (cpu_grant) begin
            mem_addr      = cpu_addr;
            mem_wdata     = cpu_wdata;
            mem_xfer_size = 4'b1000;
            mem_we        = cpu_we;
            mem_re        = !cpu_we;
        end
        cpu_stall = cpu_req && !cpu_grant && !reset;
        ext_gnt   = ext_grant;
    end

    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_LOCK     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we, ext_lock;
    logic [63:0] ext_addr, ext_wdata;
    logic [3:0]  ext_xfer_size;
    logic        ext_gnt, ext_rvalid;
    logic [63:0] ext_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_xfer_size;
    logic        mem_we, mem_re;

    dmem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_xfer_size(ext_xfer_size),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_xfer_size(mem_xfer_size),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 64-word data memory driven only by the DUT's memory port
    logic [63:0] dmem [0:63];
    bit          mem_init = 1'b0;
    assign mem_rdata = dmem[mem_addr[8:3]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 64'd0;
            mem_init <= 1'b1;
        end else if (mem_we) begin
            dmem[mem_addr[8:3]] <= mem_wdata;
        end
    end

    // Reference model: memory image, consecutive ext wait cycles, beats in the current lock
    logic [63:0] ref_mem [0:63];
    int          waited, beats;
    logic        exp_rvalid;
    logic [63:0] exp_rdata;
    bit          started;
    int          checks, errors;
    logic        seen_gnt, seen_stall, seen_rvalid;
    logic [63:0] seen_rdata, seen_erdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [63:0] a, input logic [63:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic lk, input logic [63:0] a,
                           input logic [63:0] d, input logic [3:0] sz);
        ext_req = req; ext_we = we; ext_lock = lk; ext_addr = a; ext_wdata = d; ext_xfer_size = sz;
    endtask

    // One cycle: predict, compare at mid-low phase, advance the model, cross the posedge.
    task automatic step();
        logic        eg, cg, cont;
        int          w;
        logic [63:0] e_addr, e_wdata;
        logic [3:0]  e_size;
        logic        e_we, e_re;
        #2;
        eg = 1'b0; cg = 1'b0; cont = 1'b0; w = waited;
        if (!reset) begin
            if (beats > 0 && ext_req && ext_lock && beats < MAX_LOCK) begin
                eg = 1'b1; cont = 1'b1;
            end else begin
                w  = (beats > 0) ? 0 : waited;
                eg = ext_req && (!cpu_req || w >= STARVE_LIMIT);
                cg = cpu_req && !eg;
            end
        end
        e_addr = 64'd0; e_wdata = 64'd0; e_size = 4'd0; e_we = 1'b0; e_re = 1'b0;
        if (eg) begin
            e_addr = ext_addr; e_wdata = ext_wdata; e_size = ext_xfer_size; e_we = ext_we; e_re = !ext_we;
        end else if (cg) begin
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_size = 4'b1000; e_we = cpu_we; e_re = !cpu_we;
        end
        seen_gnt = ext_gnt; seen_stall = cpu_stall; seen_rvalid = ext_rvalid;
        seen_rdata = cpu_rdata; seen_erdata = ext_rdata;
        check("ext_gnt", {63'd0, ext_gnt}, {63'd0, eg});
        check("cpu_stall", {63'd0, cpu_stall}, {63'd0, cpu_req && !cg && !reset});
        check("mem_we", {63'd0, mem_we}, {63'd0, e_we});
        check("mem_re", {63'd0, mem_re}, {63'd0, e_re});
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_xfer_size", {60'd0, mem_xfer_size}, {60'd0, e_size});
        if (started) begin
            check("ext_rvalid", {63'd0, ext_rvalid}, {63'd0, exp_rvalid});
            check("ext_rdata", ext_rdata, exp_rdata);
        end
        if (cg && !cpu_we)
            check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[8:3]]);
        if (reset) begin
            waited = 0; beats = 0; exp_rvalid = 1'b0; exp_rdata = 64'd0; started = 1'b1;
        end else begin
            exp_rvalid = eg && !ext_we;
            if (eg && !ext_we) exp_rdata = ref_mem[ext_addr[8:3]];
            if (eg && ext_we) ref_mem[ext_addr[8:3]] = ext_wdata;
            if (cg && cpu_we) ref_mem[cpu_addr[8:3]] = cpu_wdata;
            if (eg) beats = cont ? beats + 1 : (ext_lock ? 1 : 0);
            else    beats = 0;
            waited = (ext_req && !eg) ? ((w + 1 > STARVE_LIMIT) ? STARVE_LIMIT : w + 1) : 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        int first_gnt, run, stalls;
        logic [8:0] a9;
        checks = 0; errors = 0; started = 1'b0;
        waited = 0; beats = 0; exp_rvalid = 1'b0; exp_rdata = 64'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 64'd0;
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, 64'h10, 64'h1);
        set_ext(1'b1, 1'b1, 1'b1, 64'h18, 64'h2, 4'h8);
        @(negedge clk);
        step();
        do_reset();

        // CPU only: write then read back
        set_ext(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        set_cpu(1'b1, 1'b1, 64'h10, 64'hDEADBEEF);
        step();
        check("cpu_only_stall", {63'd0, seen_stall}, 64'd0);
        set_cpu(1'b1, 1'b0, 64'h10, 64'h0);
        step();
        check("cpu_only_read", seen_rdata, 64'hDEADBEEF);

        // Starvation: external read of 0x10 against a busy CPU
        do_reset();
        set_cpu(1'b1, 1'b0, 64'h40, 64'h0);
        set_ext(1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 4'h8);
        first_gnt = 0;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (seen_gnt && first_gnt == 0) first_gnt = c;
            if (c == 6) begin
                check("starve_rvalid", {63'd0, seen_rvalid}, 64'd1);
                check("starve_rdata", seen_erdata, 64'hDEADBEEF);
                check("starve_cpu_back", {63'd0, seen_stall}, 64'd0);
            end
        end
        check("starve_first_gnt", 64'(first_gnt), 64'd5);

        // Lock limit: eight beats, then one CPU cycle, then starvation restarts
        do_reset();
        set_cpu(1'b1, 1'b1, 64'h48, 64'h77);
        set_ext(1'b1, 1'b1, 1'b1, 64'h50, 64'h99, 4'h4);
        run = 0;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (seen_gnt && c <= 12) run++;
            if (c == 13) begin
                check("lock_gap_gnt", {63'd0, seen_gnt}, 64'd0);
                check("lock_gap_stall", {63'd0, seen_stall}, 64'd0);
            end
            if (c == 17) check("lock_restarve_gnt", {63'd0, seen_gnt}, 64'd1);
        end
        check("lock_run_len", 64'(run), 64'(MAX_LOCK));

        // Idle CPU: external write granted immediately
        set_cpu(1'b0, 1'b0, 64'h0, 64'h0);
        set_ext(1'b1, 1'b1, 1'b0, 64'h20, 64'h55, 4'h8);
        step();
        check("idle_ext_gnt", {63'd0, seen_gnt}, 64'd1);
        set_ext(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 4'h0);
        set_cpu(1'b1, 1'b0, 64'h20, 64'h0);
        step();
        check("idle_cpu_read", seen_rdata, 64'h55);

        // Reset mid-lock
        set_cpu(1'b0, 1'b0, 64'h0, 64'h0);
        for (int b = 0; b < 3; b++) begin
            set_ext(1'b1, 1'b1, 1'b1, 64'(8 * (b + 24)), 64'(b + 100), 4'h8);
            step();
        end
        set_cpu(1'b1, 1'b0, 64'h20, 64'h0);
        set_ext(1'b1, 1'b1, 1'b1, 64'h100, 64'hBAD, 4'h8);
        do_reset();
        check("rst_gnt", {63'd0, seen_gnt}, 64'd0);
        set_ext(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 4'h8);
        stalls = 0;
        for (int c = 1; c <= STARVE_LIMIT; c++) begin
            step();
            if (seen_stall || seen_gnt) stalls++;
        end
        check("rst_cpu_wins", 64'(stalls), 64'd0);

        // Lock dropped early
        do_reset();
        set_cpu(1'b0, 1'b0, 64'h0, 64'h0);
        set_ext(1'b1, 1'b0, 1'b1, 64'h10, 64'h0, 4'h8);
        step();
        step();
        set_cpu(1'b1, 1'b0, 64'h20, 64'h0);
        set_ext(1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 4'h8);
        step();
        check("early_drop_gnt", {63'd0, seen_gnt}, 64'd0);
        check("early_drop_stall", {63'd0, seen_stall}, 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            a9 = 9'($urandom);
            set_cpu($urandom_range(0, 9) < 7, 1'($urandom), {55'd0, a9}, {$urandom, $urandom});
            a9 = 9'($urandom);
            set_ext($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 9) < 6, {55'd0, a9},
                    {$urandom, $urandom}, 4'($urandom));
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the pipeline's DM stage and an external requester (debug/program loader). The CPU has default priority; a starvation counter bounds external wait time, and an external lock grants short atomic bursts. When the CPU loses a cycle, the arbiter raises a stall so the pipeline holds its DM-stage instruction. The block sits between the DM-stage pipeline registers and `datamem`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied external cycles before the external requester is force-granted (legal range 1–15).
- `MAX_LOCK`, default 8: maximum consecutive external beats under lock (legal range 1–15).

Ports:
- `clk` in 1: clock; everything is posedge-triggered.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: DM stage needs memory this cycle (read or write).
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 64: byte address.
- `cpu_wdata` in 64: store data.
- `cpu_rdata` out 64: combinational read data (equals `mem_rdata`).
- `cpu_stall` out 1: CPU access not performed this cycle; pipeline must hold.
- `ext_req` in 1: external access request.
- `ext_we` in 1: 1 = write, 0 = read.
- `ext_lock` in 1: request to keep ownership for the following beat.
- `ext_addr` in 64: byte address.
- `ext_wdata` in 64: store data.
- `ext_xfer_size` in 4: transfer size passed to memory.
- `ext_gnt` out 1: external access performed this cycle.
- `ext_rvalid` out 1: registered; `ext_rdata` is valid.
- `ext_rdata` out 64: registered read data of the previous granted external read.
- `mem_addr` out 64, `mem_wdata` out 64, `mem_xfer_size` out 4, `mem_we` out 1, `mem_re` out 1: drive `datamem`.
- `mem_rdata` in 64: combinational read data from `datamem`.

## Operation
- Grant is decided combinationally each cycle from the current state, the counters and the requests. Exactly one owner per cycle, or none.
- **CPU_OWN (reset state):**
  - External is granted if `ext_req && (!cpu_req || starve_cnt == STARVE_LIMIT)`. Otherwise the CPU is granted if `cpu_req`.
  - If external is granted with `ext_lock=1`, the next state is EXT_LOCKED and `lock_cnt` becomes 1.
- **EXT_LOCKED:**
  - External is granted if `ext_req && ext_lock && lock_cnt < MAX_LOCK`. Each such grant increments `lock_cnt`.
  - Otherwise the state returns to CPU_OWN, `lock_cnt` clears, and this cycle is arbitrated by CPU_OWN rules with `starve_cnt` taken as 0. The CPU therefore wins if it is requesting.
  - A lock ending on the `MAX_LOCK` limit produces at least one CPU-eligible cycle.
  - The CPU is never granted while in EXT_LOCKED.
- **`starve_cnt` (4 bit):**
  - Increments, saturating at `STARVE_LIMIT`, when `ext_req` is high and external is not granted.
  - Clears on any external grant or when `ext_req` is low.
- **Memory drive:**
  - Mux selects the owner's addr, wdata and we.
  - `mem_re = ~we` of the owner. `mem_xfer_size` is 4'b1000 for the CPU, `ext_xfer_size` for external.
  - No owner: `mem_we=0`, `mem_re=0`, addr/wdata/xfer_size = 0.
- **Outputs:**
  - `cpu_stall = cpu_req && !cpu_granted`.
  - `ext_gnt` = external granted.
  - On an external read grant, `ext_rdata <= mem_rdata` and `ext_rvalid <= 1`. Otherwise `ext_rvalid <= 0` and `ext_rdata` holds.
- Requests may change freely between cycles. The requester owns retry: a denied requester keeps `req` asserted with stable fields.

## Timing
- Grant, `cpu_stall`, `ext_gnt` and the `mem_*` outputs: zero-cycle combinational paths from the inputs and the registered state.
- Memory writes commit at the posedge ending the granted cycle.
- External read data: `ext_rvalid` one cycle after `ext_gnt`.
- Worst-case external wait without lock is `STARVE_LIMIT` cycles. The grant occurs on cycle `STARVE_LIMIT+1` of continuous `ext_req`.
- Worst-case CPU wait is `MAX_LOCK` cycles.
- Reset (synchronous, any state, including mid-lock):
  - While `reset` is high, `mem_we=0`, `mem_re=0`, `ext_gnt=0`, `cpu_stall=0`.
  - Next state is CPU_OWN; `starve_cnt=0`, `lock_cnt=0`, `ext_rvalid=0`, `ext_rdata=0`.
  - Any in-flight lock is abandoned and no write occurs.
- Simultaneous requests in CPU_OWN with `starve_cnt < STARVE_LIMIT`: CPU wins.
- A `STARVE_LIMIT` force-grant with `ext_lock=1` enters EXT_LOCKED normally.

## Test plan
- **CPU only:** `cpu_req=1`, `cpu_we=1`, addr 0x10, data 0xDEADBEEF. Required: `cpu_stall=0` every cycle; `mem_we=1`, `mem_xfer_size=4'b1000`; a later CPU read of 0x10 returns 0xDEADBEEF with no stall.
- **Starvation:** `cpu_req` and `ext_req` held high, `STARVE_LIMIT=4`. Required: external read is denied for cycles 1–4, `ext_gnt=1` with `cpu_stall=1` on cycle 5, `ext_rvalid=1` on cycle 6 with the correct data, then the CPU is granted again.
- **Lock limit:** `ext_req=1`, `ext_lock=1`, `cpu_req=1`, `MAX_LOCK=8`. Required: 8 consecutive `ext_gnt` cycles (the first after starvation), then one cycle with `ext_gnt=0` and `cpu_stall=0`, then starvation counting restarts.
- **Idle CPU:** `cpu_req=0`, external writes 0x55 to addr 0x20. Required: `ext_gnt=1` in the same cycle; a following CPU read of 0x20 returns 0x55.
- **Reset mid-lock:** after 3 locked external writes, assert `reset` for one cycle with `ext_req=1`. Required: `mem_we=0` and `ext_gnt=0` during reset; state is CPU_OWN afterwards; a simultaneous `cpu_req` then wins for the first `STARVE_LIMIT` cycles.
- **Lock dropped early:** `ext_lock` falls after 2 beats while `cpu_req=1`. Required: the CPU is granted in that same cycle and `ext_gnt=0`.
